// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt controller for the 8-bit CPU.
//
// Captures rising edges on the external request lines into pending bits.
// It picks the lowest-index enabled pending request and, at a fetch
// boundary, redirects the PC to that request's vector. In the same cycle it
// pushes the interrupted PC onto the return stack. On return-from-interrupt
// it pops the stack, then selects the stack output for one cycle.
//
// Configuration macro:
//   IRQ_SYNC_EN  defined   : each irq_in bit goes through a 2-flop synchronizer
//                            before edge detection (request-to-pending = 3 edges)
//                undefined : irq_in feeds edge detection directly (1 edge);
//                            irq_in must then be synchronous to clk.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   irq_in         in   [NIRQ] raw request lines, rising edge raises a request
//   mask_we        in   mask write strobe
//   mask_wd        in   [NIRQ] new mask value, 1 = line enabled
//   instr_boundary in   CPU is at a fetch boundary this cycle
//   pc_next        in   [PCW] next fetch address (return address)
//   reti           in   CPU decoded return-from-interrupt this cycle
//   push           out  return-stack push strobe
//   push_data      out  [PCW] value to push
//   pop            out  return-stack pop strobe
//   pc_sel         out  PC mux takes pc_irq at the next edge
//   pc_irq         out  [PCW] selected vector
//   pc_ret_sel     out  PC mux takes the stack output at the next edge
//   irq_active     out  handler in progress
//   irq_id         out  [IDW] index of the request being serviced
//   pending        out  [NIRQ] pending request bits
//
// Handshake: the strobes are single-cycle, combinational and unacknowledged.
// The PC mux and the stack act on them at the next clk edge. push is valid
// only together with push_data, and pc_sel only together with pc_irq. There is
// no ready/back-pressure path.
//
// Debug: the FSM state is held in the enum signal 'state' (IDLE/SERVICE/RESTORE).

module irq_ctrl #(
  parameter int          IDW         = 2,
  parameter int          PCW         = 10,
  parameter int unsigned VECTOR_BASE = 'h3F0,
  parameter int          VEC_SHIFT   = 2,
  localparam int         NIRQ        = 2 ** IDW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  input  logic            instr_boundary,
  input  logic [PCW-1:0]  pc_next,
  input  logic            reti,
  output logic            push,
  output logic [PCW-1:0]  push_data,
  output logic            pop,
  output logic            pc_sel,
  output logic [PCW-1:0]  pc_irq,
  output logic            pc_ret_sel,
  output logic            irq_active,
  output logic [IDW-1:0]  irq_id,
  output logic [NIRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t          state;
  logic [NIRQ-1:0] irq_src;
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] pending_q;
  logic [NIRQ-1:0] mask_q;
  logic [NIRQ-1:0] edge_set;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr;
  logic [IDW-1:0]  winner;
  logic [PCW-1:0]  vector;
  logic            take;

`ifdef IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1;
  logic [NIRQ-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_src = sync2;
`else
  assign irq_src = irq_in;
`endif

  assign edge_set = irq_src & ~irq_prev;
  assign eligible = pending_q & mask_q;

  // Lowest set index wins. Scanning from the top down and overwriting
  // leaves the lowest index in winner.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  assign take   = (state == IDLE) && instr_boundary && (|eligible);
  assign vector = PCW'(VECTOR_BASE) + (PCW'(winner) << VEC_SHIFT);

  always_comb begin
    clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      clr[i] = take && (winner == IDW'(i));
    end
  end

  // Edge capture, pending and mask. A new edge overrides a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      irq_prev  <= irq_src;
      pending_q <= (pending_q & ~clr) | edge_set;
      if (mask_we) mask_q <= mask_wd;
    end
  end

  // Control FSM. Only one return level is ever pushed, because nesting is
  // not allowed while in SERVICE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            irq_id <= winner;
            state  <= SERVICE;
          end
        end
        SERVICE: begin
          if (reti) state <= RESTORE;
        end
        RESTORE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are combinational so that the PC mux and the stack act at the
  // very next edge. When idle, pc_irq rests at the base vector.
  assign push       = take;
  assign push_data  = take ? pc_next : '0;
  assign pc_sel     = take;
  assign pc_irq     = take ? vector : PCW'(VECTOR_BASE);
  assign pop        = (state == SERVICE) && reti;
  assign pc_ret_sel = (state == RESTORE);
  assign irq_active = (state != IDLE);
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl.
// Inputs are driven at the falling edge. Outputs are sampled 2 time units
// later, which is well away from the rising edge. Expected output words go
// into exp_q and are popped when the DUT output is sampled.

module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wd = '0;
  logic       instr_boundary = 1'b0;
  logic [9:0] pc_next = '0;
  logic       reti = 1'b0;
  logic       push;
  logic [9:0] push_data;
  logic       pop;
  logic       pc_sel;
  logic [9:0] pc_irq;
  logic       pc_ret_sel;
  logic       irq_active;
  logic [1:0] irq_id;
  logic [3:0] pending;

  logic [30:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wd(mask_wd), .instr_boundary(instr_boundary), .pc_next(pc_next),
    .reti(reti), .push(push), .push_data(push_data), .pop(pop),
    .pc_sel(pc_sel), .pc_irq(pc_irq), .pc_ret_sel(pc_ret_sel),
    .irq_active(irq_active), .irq_id(irq_id), .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // expected-word builders: {push,push_data,pop,pc_sel,pc_irq,pc_ret_sel,irq_active,irq_id,pending}
  function automatic logic [30:0] ex(logic p, logic [9:0] pd, logic pp, logic ps,
                                     logic [9:0] pi, logic rs, logic act,
                                     logic [1:0] id, logic [3:0] pend);
    return {p, pd, pp, ps, pi, rs, act, id, pend};
  endfunction

  function automatic logic [30:0] idle_e(logic [1:0] id, logic [3:0] pend);
    return ex(1'b0, 10'h000, 1'b0, 1'b0, 10'h3F0, 1'b0, 1'b0, id, pend);
  endfunction

  function automatic logic [30:0] svc_e(logic [1:0] id, logic [3:0] pend);
    return ex(1'b0, 10'h000, 1'b0, 1'b0, 10'h3F0, 1'b0, 1'b1, id, pend);
  endfunction

  function automatic logic [30:0] pop_e(logic [1:0] id, logic [3:0] pend);
    return ex(1'b0, 10'h000, 1'b1, 1'b0, 10'h3F0, 1'b0, 1'b1, id, pend);
  endfunction

  function automatic logic [30:0] rst_e(logic [1:0] id, logic [3:0] pend);
    return ex(1'b0, 10'h000, 1'b0, 1'b0, 10'h3F0, 1'b1, 1'b1, id, pend);
  endfunction

  function automatic logic [30:0] take_e(logic [9:0] pd, logic [9:0] pi,
                                         logic [1:0] id, logic [3:0] pend);
    return ex(1'b1, pd, 1'b0, 1'b1, pi, 1'b0, 1'b0, id, pend);
  endfunction

  // checker
  task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                       input logic ib, input logic [9:0] pcn, input logic rt);
    irq_in = irq; mask_we = mwe; mask_wd = mwd;
    instr_boundary = ib; pc_next = pcn; reti = rt;
  endtask

  task automatic cyc(input string tag, input logic [30:0] e);
    logic [30:0] got;
    exp_q.push_back(e);
    #2;
    got = {push, push_data, pop, pc_sel, pc_irq, pc_ret_sel, irq_active, irq_id, pending};
    check(tag, got, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  // extra cycles spent in the input synchronizer (none when it is absent)
  task automatic drain(input logic [30:0] e);
    for (int k = 1; k < LAT; k++) cyc("sync_wait", e);
  endtask

  task automatic take_one(input logic [1:0] i, input logic [9:0] pc, input logic [1:0] prev_id);
    logic [3:0] bit_i;
    logic [9:0] vec;
    bit_i = 4'(1) << i;
    vec   = 10'h3F0 + 10'(i) * 10'd4;
    drive(bit_i, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("rnd_pulse", idle_e(prev_id, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    drain(idle_e(prev_id, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b1, pc, 1'b0);
    cyc("rnd_take", take_e(pc, vec, prev_id, bit_i));
  endtask

  task automatic leave(input logic [1:0] i);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("svc", svc_e(i, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1);
    cyc("pop", pop_e(i, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("restore", rst_e(i, 4'h0));
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] ri;
    logic [9:0] rpc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc("reset", idle_e(2'd0, 4'h0));
    reset = 1'b0;

    // T1: masked request is latched; pre-write mask governs; take line 1
    drive(4'h2, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t1_pulse", idle_e(2'd0, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    drain(idle_e(2'd0, 4'h0));
    drive(4'h0, 1'b1, 4'hF, 1'b1, 10'h025, 1'b0);
    cyc("t1_premask", idle_e(2'd0, 4'h2));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h025, 1'b0);
    cyc("t1_take", take_e(10'h025, 10'h3F4, 2'd0, 4'h2));
    drive(4'h1, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    cyc("t1_svc", svc_e(2'd1, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    drain(svc_e(2'd1, 4'h0));
    cyc("t1_nonest", svc_e(2'd1, 4'h1));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1);
    cyc("t1_pop", pop_e(2'd1, 4'h1));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    cyc("t1_restore", rst_e(2'd1, 4'h1));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h100, 1'b0);
    cyc("t1_b2b", take_e(10'h100, 10'h3F0, 2'd1, 4'h1));
    leave(2'd0);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t1_idle", idle_e(2'd0, 4'h0));

    // T2: simultaneous edges on lines 3 and 0; 0 first, then 3
    drive(4'h9, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t2_pulse", idle_e(2'd0, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    drain(idle_e(2'd0, 4'h0));
    cyc("t2_wait", idle_e(2'd0, 4'h9));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h055, 1'b0);
    cyc("t2_take0", take_e(10'h055, 10'h3F0, 2'd0, 4'h9));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t2_svc0", svc_e(2'd0, 4'h8));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1);
    cyc("t2_pop0", pop_e(2'd0, 4'h8));
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t2_rest0", rst_e(2'd0, 4'h8));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h077, 1'b0);
    cyc("t2_take3", take_e(10'h077, 10'h3FC, 2'd0, 4'h8));
    leave(2'd3);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t2_idle", idle_e(2'd3, 4'h0));

    // T3: reti in IDLE is ignored; a held level raises one request only
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1);
    cyc("t3_reti_idle", idle_e(2'd3, 4'h0));
    for (int k = 0; k < 10; k++) begin
      drive(4'h4, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
      cyc("t3_hold", idle_e(2'd3, (k >= LAT) ? 4'h4 : 4'h0));
    end
    drive(4'h4, 1'b0, 4'h0, 1'b1, 10'h1A0, 1'b0);
    cyc("t3_take", take_e(10'h1A0, 10'h3F8, 2'd3, 4'h4));
    drive(4'h4, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    cyc("t3_svc_held", svc_e(2'd2, 4'h0));
    leave(2'd2);
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    cyc("t3_once", idle_e(2'd2, 4'h0));

    // T4: reset during SERVICE
    take_one(2'd1, 10'h2AA, 2'd2);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b0);
    cyc("t4_svc", svc_e(2'd1, 4'h0));
    reset = 1'b1;
    cyc("t4_rst_mid", idle_e(2'd0, 4'h0));
    reset = 1'b0;
    drive(4'h0, 1'b0, 4'h0, 1'b0, 10'h000, 1'b1);
    cyc("t4_reti", idle_e(2'd0, 4'h0));
    drive(4'h1, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    cyc("t4_pulse", idle_e(2'd0, 4'h0));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h000, 1'b0);
    drain(idle_e(2'd0, 4'h0));
    drive(4'h0, 1'b1, 4'hF, 1'b1, 10'h000, 1'b0);
    cyc("t4_mask_clr", idle_e(2'd0, 4'h1));
    drive(4'h0, 1'b0, 4'h0, 1'b1, 10'h03A, 1'b0);
    cyc("t4_take", take_e(10'h03A, 10'h3F0, 2'd0, 4'h1));
    leave(2'd0);

    // random request line and return address
    prev = 2'd0;
    for (int n = 0; n < 8; n++) begin
      ri  = 2'($urandom_range(0, 3));
      rpc = 10'($urandom_range(0, 1023));
      take_one(ri, rpc, prev);
      leave(ri);
      prev = ri;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
